uart_tx: RTL and testbench

- Serial UART transmitter; the transmit-side counterpart of the console-mux UART receiver. It shares that block's frame format parameters and bit timing.
- Accepts parallel words over a valid/ready handshake into a one-deep holding register.
- Serialises each word as start bit, data bits (LSB first), optional parity bit and 1-2 stop bits on a registered, glitch-free line.
- Sits between console-mux arbitration logic and the physical TX pin.

---
 rtl/uart_tx_pkg.sv | 19 +
 rtl/uart_bit_timer.sv | 30 +++
 rtl/uart_tx.sv | 153 +++++++++++++++
 tb/tb_uart_tx.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmitter: FSM state encodings and parity modes.
// State encodings match the receiver so both sides decode identically in debug views.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    SmIdle   = 3'd0,
    SmStart  = 3'd1,
    SmData   = 3'd2,
    SmParity = 3'd3,
    SmStop   = 3'd4
  } uart_state_e;

  localparam bit ParityEven = 1'b0;
  localparam bit ParityOdd  = 1'b1;

  // Wide enough to count up to 9 data bits.
  localparam int unsigned BitCntW = 4;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-time counter: counts 0..CLK_PER_BIT-1 and ticks on the terminal count.
// Held at zero while clr_i is high.
module uart_bit_timer #(
  parameter int unsigned CLK_PER_BIT = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CntW = $clog2(CLK_PER_BIT) + 1;
  localparam logic [CntW-1:0] Terminal = CntW'(CLK_PER_BIT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick_o = !clr_i && (cnt_q == Terminal);
    cnt_d  = (clr_i || tick_o) ? '0 : cnt_q + CntW'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one-deep holding register behind a valid/ready handshake, shift
// register and framing FSM driving a registered serial line.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int unsigned DATA_BIT_COUNT   = 8,
  parameter int unsigned PARITY_BIT_COUNT = 0,
  parameter int unsigned PARITY_ODD       = 0,
  parameter int unsigned STOP_BIT_COUNT   = 1,
  parameter int unsigned CLK_PER_BIT      = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_BIT_COUNT-1:0] data_in,
  input  logic                      valid,
  output logic                      ready,
  output logic                      serial,
  output logic                      busy,
  output logic                      done
);

  localparam logic [BitCntW-1:0] LastData = BitCntW'(DATA_BIT_COUNT - 1);
  localparam logic [BitCntW-1:0] LastStop = BitCntW'(STOP_BIT_COUNT - 1);
  localparam bit                 OddPar   = (PARITY_ODD != 0) ? ParityOdd : ParityEven;

  uart_state_e               state_q, state_d;
  logic [DATA_BIT_COUNT-1:0] hold_q, hold_d;
  logic                      hold_par_q, hold_par_d;
  logic                      hold_full_q, hold_full_d;
  logic [DATA_BIT_COUNT-1:0] shift_q, shift_d;
  logic                      par_q, par_d;
  logic [BitCntW-1:0]        bit_cnt_q, bit_cnt_d;
  logic                      serial_q, serial_d;
  logic                      tick;
  logic                      accept;
  logic                      load;

  assign accept = valid && !hold_full_q;

  uart_bit_timer #(
    .CLK_PER_BIT(CLK_PER_BIT)
  ) u_bit_timer (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (state_q == SmIdle),
    .tick_o(tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= SmIdle;
      hold_q      <= '0;
      hold_par_q  <= 1'b0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      bit_cnt_q   <= '0;
      serial_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_par_q  <= hold_par_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      bit_cnt_q   <= bit_cnt_d;
      serial_q    <= serial_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_par_d  = hold_par_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    par_d       = par_q;
    bit_cnt_d   = bit_cnt_q;
    load        = 1'b0;

    unique case (state_q)
      SmIdle: begin
        if (hold_full_q) load = 1'b1;
      end
      SmStart: begin
        if (tick) begin
          state_d   = SmData;
          bit_cnt_d = '0;
        end
      end
      SmData: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == LastData) begin
            bit_cnt_d = '0;
            state_d   = (PARITY_BIT_COUNT != 0) ? SmParity : SmStop;
          end else begin
            bit_cnt_d = bit_cnt_q + BitCntW'(1);
          end
        end
      end
      SmParity: begin
        if (tick) begin
          state_d   = SmStop;
          bit_cnt_d = '0;
        end
      end
      SmStop: begin
        if (tick) begin
          if (bit_cnt_q == LastStop) begin
            bit_cnt_d = '0;
            // Holding is sampled before this cycle's accept, so a same-cycle word waits.
            if (hold_full_q) load = 1'b1;
            else             state_d = SmIdle;
          end else begin
            bit_cnt_d = bit_cnt_q + BitCntW'(1);
          end
        end
      end
      default: state_d = SmIdle;
    endcase

    if (load) begin
      state_d     = SmStart;
      shift_d     = hold_q;
      par_d       = hold_par_q;
      hold_full_d = 1'b0;
      bit_cnt_d   = '0;
    end

    if (accept) begin
      hold_d      = data_in;
      hold_par_d  = (^data_in) ^ OddPar;
      hold_full_d = 1'b1;
    end
  end

  // Line value is computed from the next state so serial is a plain flop output.
  always_comb begin
    serial_d = 1'b1;
    unique case (state_d)
      SmStart:  serial_d = 1'b0;
      SmData:   serial_d = shift_d[0];
      SmParity: serial_d = par_d;
      default:  serial_d = 1'b1;
    endcase
    done   = (state_q == SmStop) && tick && (bit_cnt_q == LastStop);
    busy   = (state_q != SmIdle);
    ready  = !hold_full_q;
    serial = serial_q;
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: five framing configurations, table-driven frames,
// hand-written corner sequences and random traffic against a per-cycle line model.
module tb_uart_tx;

  localparam int NCfg = 5;
  // cfg: 0=8N1, 1=8E1, 2=8O1, 3=8N2, 4=9O2 at 2 clocks per bit
  int dbc_c  [NCfg] = '{8, 8, 8, 8, 9};
  int par_c  [NCfg] = '{0, 1, 1, 0, 1};
  int odd_c  [NCfg] = '{0, 0, 1, 0, 1};
  int sbc_c  [NCfg] = '{1, 1, 1, 2, 2};
  int cpb_c  [NCfg] = '{8, 8, 8, 8, 2};

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [8:0]      din = '0;
  logic [NCfg-1:0] valid_v = '0;
  logic [NCfg-1:0] rdy_v, ser_v, busy_v, done_v;

  int n_cmp = 0;
  int n_err = 0;

  // Model: expected line per future cycle as {done, serial}, plus holding register.
  logic [1:0] q[$];
  logic       m_full = 1'b0;
  logic [8:0] m_word = '0;

  typedef struct {
    int         cfg;
    logic [8:0] data;
    int         nbits;
    logic [15:0] seq;  // bit i = i-th bit on the line
  } vec_t;
  vec_t tbl[6];

  always #5 clk = ~clk;

  uart_tx #(.DATA_BIT_COUNT(8), .PARITY_BIT_COUNT(0), .PARITY_ODD(0), .STOP_BIT_COUNT(1),
            .CLK_PER_BIT(8)) dut0 (
    .clk(clk), .rst(rst), .data_in(din[7:0]), .valid(valid_v[0]), .ready(rdy_v[0]),
    .serial(ser_v[0]), .busy(busy_v[0]), .done(done_v[0]));
  uart_tx #(.DATA_BIT_COUNT(8), .PARITY_BIT_COUNT(1), .PARITY_ODD(0), .STOP_BIT_COUNT(1),
            .CLK_PER_BIT(8)) dut1 (
    .clk(clk), .rst(rst), .data_in(din[7:0]), .valid(valid_v[1]), .ready(rdy_v[1]),
    .serial(ser_v[1]), .busy(busy_v[1]), .done(done_v[1]));
  uart_tx #(.DATA_BIT_COUNT(8), .PARITY_BIT_COUNT(1), .PARITY_ODD(1), .STOP_BIT_COUNT(1),
            .CLK_PER_BIT(8)) dut2 (
    .clk(clk), .rst(rst), .data_in(din[7:0]), .valid(valid_v[2]), .ready(rdy_v[2]),
    .serial(ser_v[2]), .busy(busy_v[2]), .done(done_v[2]));
  uart_tx #(.DATA_BIT_COUNT(8), .PARITY_BIT_COUNT(0), .PARITY_ODD(0), .STOP_BIT_COUNT(2),
            .CLK_PER_BIT(8)) dut3 (
    .clk(clk), .rst(rst), .data_in(din[7:0]), .valid(valid_v[3]), .ready(rdy_v[3]),
    .serial(ser_v[3]), .busy(busy_v[3]), .done(done_v[3]));
  uart_tx #(.DATA_BIT_COUNT(9), .PARITY_BIT_COUNT(1), .PARITY_ODD(1), .STOP_BIT_COUNT(2),
            .CLK_PER_BIT(2)) dut4 (
    .clk(clk), .rst(rst), .data_in(din), .valid(valid_v[4]), .ready(rdy_v[4]),
    .serial(ser_v[4]), .busy(busy_v[4]), .done(done_v[4]));

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at time %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_bit(input int c, input logic b);
    for (int i = 0; i < cpb_c[c]; i++) q.push_back({1'b0, b});
  endtask

  task automatic push_frame(input int c, input logic [8:0] w);
    logic p;
    p = (odd_c[c] != 0);
    push_bit(c, 1'b0);
    for (int i = 0; i < dbc_c[c]; i++) begin
      push_bit(c, w[i]);
      p = p ^ w[i];
    end
    if (par_c[c] != 0) push_bit(c, p);
    for (int i = 0; i < sbc_c[c]; i++) push_bit(c, 1'b1);
    q[q.size()-1] = 2'b11;
  endtask

  task automatic model_reset();
    q.delete();
    m_full = 1'b0;
  endtask

  // One clock: drive at negedge, advance model at posedge, compare 1 time unit later.
  task automatic step(input int c, input logic v, input logic [8:0] d);
    logic acc;
    @(negedge clk);
    valid_v    = '0;
    valid_v[c] = v;
    din        = d;
    @(posedge clk);
    acc = v && !m_full;
    if (q.size() > 0) q.delete(0);
    if (q.size() == 0 && m_full) begin
      push_frame(c, m_word);
      m_full = 1'b0;
    end
    if (acc) begin
      m_full = 1'b1;
      m_word = d;
    end
    #1;
    chk("serial", 16'(ser_v[c]), 16'((q.size() > 0) ? q[0][0] : 1'b1));
    chk("done",   16'(done_v[c]), 16'((q.size() > 0) ? q[0][1] : 1'b0));
    chk("busy",   16'(busy_v[c]), 16'(q.size() > 0));
    chk("ready",  16'(rdy_v[c]), 16'(!m_full));
  endtask

  task automatic drain(input int c);
    int n;
    n = 0;
    while ((q.size() != 0 || m_full) && n < 500) begin
      step(c, 1'b0, 9'($urandom));
      n++;
    end
    chk("drain_bound", 16'(n < 500), 16'(1));
    step(c, 1'b0, '0);
  endtask

  initial begin
    int nd;
    tbl[0] = '{cfg: 0, data: 9'h055, nbits: 10, seq: 16'h02AA};
    tbl[1] = '{cfg: 1, data: 9'h007, nbits: 11, seq: 16'h060E};
    tbl[2] = '{cfg: 2, data: 9'h007, nbits: 11, seq: 16'h040E};
    tbl[3] = '{cfg: 3, data: 9'h0A3, nbits: 11, seq: 16'h0746};
    tbl[4] = '{cfg: 0, data: 9'h000, nbits: 10, seq: 16'h0200};
    tbl[5] = '{cfg: 4, data: 9'h1FF, nbits: 13, seq: 16'h1BFE};

    // Reset state while rst is held.
    #12;
    for (int c = 0; c < NCfg; c++) begin
      chk("rst_serial", 16'(ser_v[c]), 16'(1));
      chk("rst_ready",  16'(rdy_v[c]), 16'(1));
      chk("rst_busy",   16'(busy_v[c]), 16'(0));
      chk("rst_done",   16'(done_v[c]), 16'(0));
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Table of single frames with hand-derived line sequences.
    foreach (tbl[t]) begin
      int c, cpb, len;
      c   = tbl[t].cfg;
      cpb = cpb_c[c];
      len = tbl[t].nbits * cpb;
      step(c, 1'b1, tbl[t].data);
      chk("tbl_ready_lo", 16'(rdy_v[c]), 16'(0));
      for (int k = 1; k <= len; k++) begin
        step(c, 1'b0, 9'($urandom));
        if (k == 1) chk("tbl_ready_hi", 16'(rdy_v[c]), 16'(1));
        chk("tbl_line", 16'(ser_v[c]), 16'(tbl[t].seq[(k-1)/cpb]));
        chk("tbl_done", 16'(done_v[c]), 16'(k == len));
      end
      step(c, 1'b0, '0);
      chk("tbl_idle", 16'({busy_v[c], ser_v[c]}), 16'(2'b01));
    end

    // Back-to-back: second word accepted while busy starts right after the first done.
    step(0, 1'b1, 9'h012);
    for (int k = 0; k < 20; k++) step(0, 1'b0, '0);
    step(0, 1'b1, 9'h034);
    chk("b2b_ready_lo", 16'(rdy_v[0]), 16'(0));
    nd = 0;
    while (done_v[0] !== 1'b1 && nd < 200) begin
      step(0, 1'b0, '0);
      nd++;
    end
    chk("b2b_done_seen", 16'(nd < 200), 16'(1));
    step(0, 1'b0, '0);
    chk("b2b_no_gap", 16'({busy_v[0], ser_v[0]}), 16'(2'b10));
    drain(0);

    // valid held while ready is low with data toggling: only the accepted word is sent.
    step(0, 1'b1, 9'h0C3);
    for (int k = 0; k < 30; k++) step(0, 1'b1, 9'($urandom));
    drain(0);

    // Reset during data bit 3, then a clean frame.
    step(0, 1'b1, 9'h0F0);
    for (int k = 0; k < 1 + 8 + 3 * 8 + 3; k++) step(0, 1'b0, '0);
    #2 rst = 1'b1;
    #1;
    chk("midrst_serial", 16'(ser_v[0]), 16'(1));
    chk("midrst_busy",   16'(busy_v[0]), 16'(0));
    chk("midrst_ready",  16'(rdy_v[0]), 16'(1));
    chk("midrst_done",   16'(done_v[0]), 16'(0));
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step(0, 1'b1, 9'h05A);
    drain(0);

    // Random traffic on every configuration.
    for (int c = 0; c < NCfg; c++) begin
      model_reset();
      for (int k = 0; k < 600; k++) step(c, 1'(($urandom % 4) == 0), 9'($urandom));
      drain(c);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
